serial_word_compare: RTL and testbench

//  Downstream consumer of the 2-bit gate-level comparator's gt/lt/eq flags.
//  - Folds NDIGITS successive 2-bit digit results, presented MSB digit first,

---
 rtl/serial_word_compare.sv | 189 ++++++++++++++++++
 tb/tb_serial_word_compare.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_compare.sv
// Folds NDIGITS MSB-first 2-bit comparator flag sets into one word-level gt/lt/eq result.
// Optional feature macro: SWC_DIFF_IDX_EN adds first_diff_idx (index of the deciding digit).
module serial_word_compare #(
  parameter int NDIGITS = 4,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             gt_in,
  input  logic             lt_in,
  input  logic             eq_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic             err,
`ifdef SWC_DIFF_IDX_EN
  output logic [IDX_W-1:0] first_diff_idx,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic             decided_q, decided_d;
  logic             dir_gt_q, dir_gt_d;
  logic             err_q, err_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
`ifdef SWC_DIFF_IDX_EN
  logic [IDX_W-1:0] idx_q, idx_d;
`endif

  logic digit_legal;
  logic accept_last;

  // Exactly one flag high: odd parity rules out 0 and 2, the AND rules out 3.
  assign digit_legal = (gt_in ^ lt_in ^ eq_in) & ~(gt_in & lt_in & eq_in);
  assign accept_last = in_valid && (count_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    decided_d = decided_q;
    dir_gt_d  = dir_gt_q;
    err_d     = err_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
`ifdef SWC_DIFF_IDX_EN
    idx_d     = idx_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          count_d   = '0;
          decided_d = 1'b0;
          dir_gt_d  = 1'b0;
          err_d     = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          eq_d      = 1'b0;
`ifdef SWC_DIFF_IDX_EN
          idx_d     = '0;
`endif
        end
      end

      S_RUN: begin
        if (in_valid) begin
          if (!digit_legal) begin
            // Illegal flag sets never decide; the digit still counts.
            err_d = 1'b1;
          end else if (!decided_q && (gt_in || lt_in)) begin
            decided_d = 1'b1;
            dir_gt_d  = gt_in;
`ifdef SWC_DIFF_IDX_EN
            idx_d     = count_q;
`endif
          end

          if (accept_last) begin
            state_d = S_DONE;
            count_d = '0;
            gt_d    = decided_d & dir_gt_d;
            lt_d    = decided_d & ~dir_gt_d;
            eq_d    = ~decided_d;
          end else begin
            count_d = count_q + IDX_W'(1);
          end
        end
      end

      S_DONE: begin
        if (res_ready) begin
          gt_d = 1'b0;
          lt_d = 1'b0;
          eq_d = 1'b0;
          if (start) begin
            // Back-to-back word: skip IDLE and start clean.
            state_d   = S_RUN;
            count_d   = '0;
            decided_d = 1'b0;
            dir_gt_d  = 1'b0;
            err_d     = 1'b0;
`ifdef SWC_DIFF_IDX_EN
            idx_d     = '0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase

    in_ready_d  = (state_d == S_RUN);
    res_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      decided_q   <= 1'b0;
      dir_gt_q    <= 1'b0;
      err_q       <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SWC_DIFF_IDX_EN
      idx_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      decided_q   <= decided_d;
      dir_gt_q    <= dir_gt_d;
      err_q       <= err_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
`ifdef SWC_DIFF_IDX_EN
      idx_q       <= idx_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign err       = err_q;
  assign busy      = busy_q;
`ifdef SWC_DIFF_IDX_EN
  assign first_diff_idx = idx_q;
`endif

endmodule

// File: tb/tb_serial_word_compare.sv
// Directed, table-driven bench for serial_word_compare with NDIGITS=4 (8-bit words).
module tb_serial_word_compare;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       gt_in = 1'b0;
  logic       lt_in = 1'b0;
  logic       eq_in = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       gt, lt, eq, err, busy;
`ifdef SWC_DIFF_IDX_EN
  logic [1:0] first_diff_idx;
`endif

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  serial_word_compare #(.NDIGITS(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gt_in     (gt_in),
    .lt_in     (lt_in),
    .eq_in     (eq_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq),
    .err       (err),
`ifdef SWC_DIFF_IDX_EN
    .first_diff_idx (first_diff_idx),
`endif
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         gap;
    int         bad;
    logic [2:0] bflags;
    logic       eg, el, ee, er;
    logic [1:0] idx;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result(input string tag, input logic eg, input logic el,
                            input logic ee, input logic er, input logic [1:0] idx);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd1);
    chk({tag, ".gt"}, 32'(gt), 32'(eg));
    chk({tag, ".lt"}, 32'(lt), 32'(el));
    chk({tag, ".eq"}, 32'(eq), 32'(ee));
    chk({tag, ".err"}, 32'(err), 32'(er));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
`ifdef SWC_DIFF_IDX_EN
    chk({tag, ".idx"}, 32'(first_diff_idx), 32'(idx));
`else
    if (idx > 2'd3) chk({tag, ".idx_range"}, 32'(idx), 32'd0);
`endif
  endtask

  // Feed one word; optionally start it and optionally consume the result.
  task automatic run_word(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int gap, input int bad, input logic [2:0] bflags,
                          input bit do_start, input bit do_release,
                          input logic eg, input logic el, input logic ee,
                          input logic er, input logic [1:0] idx);
    logic [1:0] ad, bd;
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        step();
      end
      ad = a[7-2*i -: 2];
      bd = b[7-2*i -: 2];
      {gt_in, lt_in, eq_in} = (i == bad) ? bflags : {ad > bd, ad < bd, ad == bd};
      in_valid = 1'b1;
      chk($sformatf("%s.in_ready_d%0d", tag, i), 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      {gt_in, lt_in, eq_in} = 3'b000;
      if (i < 3) chk($sformatf("%s.early_valid_d%0d", tag, i), 32'(res_valid), 32'd0);
    end
    chk_result(tag, eg, el, ee, er, idx);
    $display("word %s a=%02h b=%02h gap=%0d -> gt=%0b lt=%0b eq=%0b err=%0b",
             tag, a, b, gap, gt, lt, eq, err);
    if (do_release) begin
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk({tag, ".rel_valid"}, 32'(res_valid), 32'd0);
      chk({tag, ".rel_busy"}, 32'(busy), 32'd0);
      chk({tag, ".rel_gt_lt_eq"}, {29'd0, gt, lt, eq}, 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".outs"}, {25'd0, in_ready, res_valid, gt, lt, eq, err, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           a      b      gap bad bflags  gt   lt   eq   err  idx
    vecs[0] = '{8'hB4, 8'hB1, 0, -1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
    vecs[1] = '{8'h3C, 8'h7C, 0, -1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[2] = '{8'h1C, 8'h2C, 1, -1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[3] = '{8'h5A, 8'h5A, 0, -1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[4] = '{8'h5A, 8'h5A, 3, -1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[5] = '{8'h00, 8'h00, 0,  2, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
    vecs[6] = '{8'h01, 8'h00, 0,  0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3};
    vecs[7] = '{8'h80, 8'h7F, 2, -1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};

    // Reset state
    #5;
    chk_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset_idle");

    for (int v = 0; v < 8; v++) begin
      run_word($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].gap, vecs[v].bad,
               vecs[v].bflags, 1'b1, 1'b1, vecs[v].eg, vecs[v].el, vecs[v].ee,
               vecs[v].er, vecs[v].idx);
    end

    // Backpressure: result holds for 5 cycles, start in DONE ignored
    run_word("bp", 8'hB4, 8'hB1, 0, -1, 3'b000, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      step();
      start = 1'b0;
      chk_result($sformatf("bp_hold%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp.rel_busy", 32'(busy), 32'd0);
    $display("backpressure hold done busy=%0b", busy);

    // Mid-word reset: outputs drop immediately, then a fresh word works
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      {gt_in, lt_in, eq_in} = 3'b100;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    {gt_in, lt_in, eq_in} = 3'b000;
    rst_n = 1'b0;
    #2;
    chk_all_zero("midword_reset");
    step();
    rst_n = 1'b1;
    step();
    chk_all_zero("after_midword_reset");
    $display("mid-word reset done");
    run_word("post_rst", 8'h3C, 8'h7C, 0, -1, 3'b000, 1'b1, 1'b1,
             1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // Back-to-back: start with res_ready in DONE goes straight to RUN
    run_word("b2b_a", 8'hB4, 8'hB1, 0, -1, 3'b000, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    start = 1'b1;
    res_ready = 1'b1;
    step();
    start = 1'b0;
    res_ready = 1'b0;
    chk("b2b.in_ready", 32'(in_ready), 32'd1);
    chk("b2b.res_valid", 32'(res_valid), 32'd0);
    chk("b2b.busy", 32'(busy), 32'd1);
    chk("b2b.err_cleared", 32'(err), 32'd0);
    run_word("b2b_b", 8'h1C, 8'h2C, 0, -1, 3'b000, 1'b0, 1'b1,
             1'b0, 1'b1, 1'b0, 1'b0, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
